// File: rtl/hilo_pkg.sv
// hilo_pkg: shared widths, op encodings, FSM states and the pending-result
// payload used by hilo_unit and hilo_countdown.
package hilo_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned OP_W   = 3;
   localparam int unsigned CNT_W  = 5;

   // Op encodings; these mirror the HILO_* defines the decoder consumes.
   // Code 7 is unassigned and behaves as OP_NONE.
   typedef enum logic [OP_W-1:0] {
      OP_NONE = 3'd0,
      OP_MULT = 3'd1,
      OP_DIV  = 3'd2,
      OP_MTHI = 3'd3,
      OP_MTLO = 3'd4,
      OP_MFHI = 3'd5,
      OP_MFLO = 3'd6
   } hilo_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } hilo_state_e;

   // Result captured at issue, held until the commit edge.
   typedef struct packed {
      logic [DATA_W-1:0] hi;
      logic [DATA_W-1:0] lo;
      logic              div_zero;
   } hilo_pending_t;

   // True for every op that touches HI/LO (and therefore stalls while busy).
   function automatic logic is_hilo_access(input logic [OP_W-1:0] op);
      return (op inside {OP_MULT, OP_DIV, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO});
   endfunction

endpackage

// File: rtl/hilo_countdown.sv
// hilo_countdown: loadable down-counter for multi-cycle units.
//   clock, reset : clock and asynchronous active-high reset
//   load, value  : load value into the counter (load has priority)
//   dec          : decrement by one; saturates at zero
//   zero         : counter currently holds zero
module hilo_countdown
   import hilo_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] value,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO register stage behind the ALU. Holds mult/div results for
// MULT_CYCLES/DIV_CYCLES edges before committing them, serves mthi/mtlo/
// mfhi/mflo, and requests a stall for any HI/LO access while busy.
//   clock, reset         : clock and asynchronous active-high reset
//   sig_hilo_op          : op code (see hilo_op_e)
//   alu_hi, alu_lo       : ALU mult/div result for the current op
//   src_a, src_b         : mthi/mtlo write data; divisor (zero check only)
//   read_data            : combinational HI/LO for mfhi/mflo, else 0
//   hi_out, lo_out       : architectural HI/LO
//   busy                 : mult/div in flight (registered)
//   stall_req            : current op held upstream this cycle
//   div_zero             : pulse in the cycle after a divide-by-zero commit
module hilo_unit
   import hilo_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 4,
   parameter int unsigned DIV_CYCLES  = 12
)(
   input  logic              clock,
   input  logic              reset,
   input  logic [OP_W-1:0]   sig_hilo_op,
   input  logic [DATA_W-1:0] alu_hi,
   input  logic [DATA_W-1:0] alu_lo,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   output logic [DATA_W-1:0] read_data,
   output logic [DATA_W-1:0] hi_out,
   output logic [DATA_W-1:0] lo_out,
   output logic              busy,
   output logic              stall_req,
   output logic              div_zero
);

   // Counter holds N-1 after issue so commit lands on edge issue+N.
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   hilo_state_e   state;
   hilo_pending_t pending;
   logic          is_mult;
   logic          is_div;
   logic          cnt_load;
   logic          cnt_dec;
   logic          cnt_zero;

   assign busy     = (state == ST_BUSY);
   assign is_mult  = (sig_hilo_op == OP_MULT);
   assign is_div   = (sig_hilo_op == OP_DIV);
   assign cnt_load = !busy && (is_mult || is_div);
   assign cnt_dec  = busy && !cnt_zero;

   hilo_countdown u_countdown (
      .clock (clock),
      .reset (reset),
      .load  (cnt_load),
      .dec   (cnt_dec),
      .value (is_div ? DIV_LOAD : MULT_LOAD),
      .zero  (cnt_zero)
   );

   assign stall_req = busy && is_hilo_access(sig_hilo_op);

   // Reads bypass nothing: HI/LO as of this cycle, blanked while stalled.
   always_comb begin
      read_data = '0;
      if (!busy) begin
         if (sig_hilo_op == OP_MFHI) begin
            read_data = hi_out;
         end else if (sig_hilo_op == OP_MFLO) begin
            read_data = lo_out;
         end
      end
   end

   // FSM, pending result and architectural HI/LO.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         pending  <= '0;
         hi_out   <= '0;
         lo_out   <= '0;
         div_zero <= 1'b0;
      end else begin
         div_zero <= 1'b0;
         case (state)
            ST_IDLE: begin
               case (sig_hilo_op)
                  OP_MULT: begin
                     pending <= '{hi: alu_hi, lo: alu_lo, div_zero: 1'b0};
                     state   <= ST_BUSY;
                  end
                  OP_DIV: begin
                     pending <= '{hi: alu_hi, lo: alu_lo, div_zero: (src_b == '0)};
                     state   <= ST_BUSY;
                  end
                  OP_MTHI: hi_out <= src_a;
                  OP_MTLO: lo_out <= src_a;
                  default: ;
               endcase
            end
            ST_BUSY: begin
               if (cnt_zero) begin
                  state <= ST_IDLE;
                  // A divide by zero leaves HI/LO untouched and flags instead.
                  if (pending.div_zero) begin
                     div_zero <= 1'b1;
                  end else begin
                     hi_out <= pending.hi;
                     lo_out <= pending.lo;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed scenarios plus random ops against a cycle-count
// reference model of the HI/LO stage.
module tb_hilo_unit;
   import hilo_pkg::*;

   localparam int unsigned MC = 4;
   localparam int unsigned DC = 12;

   logic        clock = 1'b0;
   logic        reset;
   logic [2:0]  sig_hilo_op;
   logic [31:0] alu_hi, alu_lo, src_a, src_b;
   logic [31:0] read_data, hi_out, lo_out;
   logic        busy, stall_req, div_zero;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [31:0] m_hi, m_lo, m_phi, m_plo;
   bit          m_pzero, m_inflight, m_dz;
   int          m_remaining;
   bit          last_stall;

   hilo_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clock       (clock),
      .reset       (reset),
      .sig_hilo_op (sig_hilo_op),
      .alu_hi      (alu_hi),
      .alu_lo      (alu_lo),
      .src_a       (src_a),
      .src_b       (src_b),
      .read_data   (read_data),
      .hi_out      (hi_out),
      .lo_out      (lo_out),
      .busy        (busy),
      .stall_req   (stall_req),
      .div_zero    (div_zero)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0;
      m_pzero = 0; m_inflight = 0; m_dz = 0; m_remaining = 0;
   endtask

   // One clock edge of architectural behaviour: an in-flight op counts down
   // N edges from issue; otherwise the presented op takes effect.
   task automatic model_edge(input logic [2:0] op, input logic [31:0] ahi, alo, sa, sb);
      m_dz = 0;
      if (m_inflight) begin
         m_remaining--;
         if (m_remaining == 0) begin
            m_inflight = 0;
            if (m_pzero) m_dz = 1;
            else begin
               m_hi = m_phi;
               m_lo = m_plo;
            end
         end
      end else begin
         case (op)
            3'd1: begin m_inflight = 1; m_remaining = MC; m_phi = ahi; m_plo = alo; m_pzero = 0; end
            3'd2: begin m_inflight = 1; m_remaining = DC; m_phi = ahi; m_plo = alo; m_pzero = (sb == 0); end
            3'd3: m_hi = sa;
            3'd4: m_lo = sa;
            default: ;
         endcase
      end
   endtask

   // Present an op for one cycle, check combinational outputs before the
   // edge and registered outputs after it.
   task automatic step(input logic [2:0] op, input logic [31:0] ahi, alo, sa, sb);
      logic [31:0] exp_rd;
      bit          exp_st;
      @(negedge clock);
      sig_hilo_op = op; alu_hi = ahi; alu_lo = alo; src_a = sa; src_b = sb;
      #1;
      exp_st = m_inflight && (op inside {[3'd1:3'd6]});
      if (m_inflight)      exp_rd = '0;
      else if (op == 3'd5) exp_rd = m_hi;
      else if (op == 3'd6) exp_rd = m_lo;
      else                 exp_rd = '0;
      last_stall = stall_req;
      chk("stall_req", 32'(stall_req), 32'(exp_st));
      chk("read_data", read_data, exp_rd);
      @(posedge clock);
      model_edge(op, ahi, alo, sa, sb);
      #1;
      chk("hi_out", hi_out, m_hi);
      chk("lo_out", lo_out, m_lo);
      chk("busy", 32'(busy), 32'(m_inflight));
      chk("div_zero", 32'(div_zero), 32'(m_dz));
   endtask

   task automatic idle_until_free();
      int guard = 0;
      while (busy && guard < 40) begin
         step(OP_NONE, '0, '0, '0, '0);
         guard++;
      end
      chk("drain_timeout", 32'(busy), 32'(0));
   endtask

   initial begin
      int busy_len, guard, dz_count;
      logic [2:0]  rop;
      logic [31:0] rb;

      reset = 1'b1;
      sig_hilo_op = '0; alu_hi = '0; alu_lo = '0; src_a = '0; src_b = '0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      chk("rst_hi", hi_out, 32'h0);
      chk("rst_lo", lo_out, 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_dz", 32'(div_zero), 32'h0);
      reset = 1'b0;

      // Idle read after reset
      step(OP_MFHI, '0, '0, '0, '0);
      chk("idle_mfhi", read_data, 32'h0);

      // MULT 2000000000 x 3
      step(OP_MULT, 32'h00000001, 32'h65a0bc00, '0, 32'd3);
      busy_len = busy ? 1 : 0;
      guard = 0;
      while (busy && guard < 20) begin
         step(OP_MFLO, '0, '0, '0, '0);
         chk("mflo_busy_stall", 32'(last_stall), 32'h1);
         busy_len += busy ? 1 : 0;
         guard++;
      end
      chk("mult_busy_len", busy_len, MC);
      step(OP_MFLO, '0, '0, '0, '0);
      chk("mflo_after_mult", read_data, 32'h65a0bc00);
      step(OP_MFHI, '0, '0, '0, '0);
      chk("mfhi_after_mult", read_data, 32'h00000001);

      // DIV 11/3, then MULT offered in the commit cycle
      step(OP_DIV, 32'd2, 32'd3, '0, 32'd3);
      repeat (DC - 1) step(OP_NONE, '0, '0, '0, '0);
      step(OP_MULT, 32'h11, 32'h22, '0, '0);
      chk("mult_commit_stall", 32'(last_stall), 32'h1);
      chk("div_hi", hi_out, 32'd2);
      chk("div_lo", lo_out, 32'd3);
      step(OP_MULT, 32'h11, 32'h22, '0, '0);
      chk("mult_accept", 32'(last_stall), 32'h0);
      chk("mult_accept_busy", 32'(busy), 32'h1);
      idle_until_free();
      chk("mult2_hi", hi_out, 32'h11);

      // Divide by zero with preloaded HI/LO
      step(OP_MTHI, '0, '0, 32'hAAAAAAAA, '0);
      step(OP_MTLO, '0, '0, 32'h5555FFFF, '0);
      step(OP_DIV, 32'h77, 32'h99, '0, 32'h0);
      dz_count = 0;
      repeat (DC + 2) begin
         step(OP_NONE, '0, '0, '0, '0);
         dz_count += div_zero ? 1 : 0;
      end
      chk("dz_hi", hi_out, 32'hAAAAAAAA);
      chk("dz_lo", lo_out, 32'h5555FFFF);
      chk("dz_pulses", dz_count, 1);

      // Reset in the middle of a divide
      step(OP_DIV, 32'h3, 32'h4, '0, 32'd5);
      repeat (4) step(OP_NONE, '0, '0, '0, '0);
      @(negedge clock);
      sig_hilo_op = OP_MFHI;
      #2 reset = 1'b1;
      #1;
      model_reset();
      chk("arst_hi", hi_out, 32'h0);
      chk("arst_lo", lo_out, 32'h0);
      chk("arst_busy", 32'(busy), 32'h0);
      chk("arst_stall", 32'(stall_req), 32'h0);
      @(posedge clock);
      #1 reset = 1'b0;
      step(OP_MTLO, '0, '0, 32'h0000002A, '0);
      chk("post_rst_mtlo", lo_out, 32'h2A);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         rop = 3'($urandom_range(0, 7));
         rb  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         step(rop, $urandom, $urandom, $urandom, rb);
      end
      idle_until_free();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

- Stage directly downstream of the ALU.
- Captures the ALU's `hi`/`lo` mult/div results into the architectural HI and LO registers, modelling multi-cycle multiply/divide latency.
- Serves `mfhi`/`mflo`/`mthi`/`mtlo`, and asserts a pipeline stall when an access conflicts with an in-flight operation.

## Interface
Parameters:
- `MULT_CYCLES`, 4: cycles from MULT issue edge to HI/LO commit edge; legal range 1..31.
- `DIV_CYCLES`, 12: cycles from DIV issue edge to HI/LO commit edge; legal range 1..31.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `sig_hilo_op`  in  3: NONE=0, MULT=1, DIV=2, MTHI=3, MTLO=4, MFHI=5, MFLO=6; 7 is treated as NONE.
- `alu_hi`  in  32: ALU `hi` output for the current op.
- `alu_lo`  in  32: ALU `lo` output for the current op.
- `src_a`  in  32: write data for MTHI/MTLO.
- `src_b`  in  32: divisor, checked only for DIV by-zero.
- `read_data`  out  32: HI (MFHI) or LO (MFLO), combinational; 0 for any other op.
- `hi_out`  out  32: architectural HI register.
- `lo_out`  out  32: architectural LO register.
- `busy`  out  1: a mult/div is in flight.
- `stall_req`  out  1: current op cannot be accepted this cycle; the upstream stage holds it.
- `div_zero`  out  1: one-cycle pulse on the commit edge of a DIV whose `src_b` was 0.

## Operation
- States: IDLE, BUSY.
- Reset:
  - HI = LO = 0; state IDLE; counter 0; pending regs 0.
  - `busy` = `stall_req` = `div_zero` = 0.
- IDLE, op MULT or DIV:
  - Latch `alu_hi`/`alu_lo` into pending regs.
  - Latch the zero flag (`src_b` == 0, DIV only).
  - Load counter with N−1 (N = MULT_CYCLES or DIV_CYCLES); go BUSY.
- BUSY:
  - Counter decrements each edge.
  - On the edge where the counter is 0, commit pending to HI/LO and return to IDLE.
  - DIV with the zero flag set: HI/LO are left unchanged, and `div_zero` pulses the cycle after the commit edge.
- IDLE, MTHI/MTLO: HI or LO ← `src_a` on that edge; the other register is untouched.
- IDLE, MFHI/MFLO: `read_data` = current HI/LO combinationally, with no added latency.
- `stall_req` = `busy` AND (op ∈ {MULT, DIV, MTHI, MTLO, MFHI, MFLO}).
  - A stalled op has no effect; the pipeline re-presents it.
  - `read_data` is 0 while stalled.
- `busy` = (state == BUSY); it is a registered output.
- Arithmetic:
  - The counter is 5 bits, unsigned.
  - HI/LO are stored verbatim; no sign handling occurs in this block.

## Timing
- Issue on edge k → HI/LO are visible on `hi_out`/`lo_out` after edge k+N.
- `busy` is high from after edge k through edge k+N.
- N=1: `busy` is high for exactly one cycle; the commit happens on edge k+1.
- Back-to-back ops:
  - An op presented in the cycle after the commit edge is accepted with no bubble.
  - An op presented in the commit cycle itself (`busy` still 1) stalls for exactly one cycle.
- MFHI presented in the cycle after commit returns the new value.
- Reset asserted mid-BUSY:
  - The in-flight result is discarded and HI/LO go to 0 immediately (asynchronous).
  - `busy` and `stall_req` drop immediately.
- Deassertion of `reset` is synchronous to `clock`; the first op is accepted on the first edge after deassertion.

## Structure
- The HILO_* op encodings go in the shared `ManBearPig.h` defines header, alongside the ALU control codes.
- The decoder/control unit also consumes these encodings.
- One sub-module: `hilo_countdown`.
  - Ports: loadable 5-bit down-counter with `load`, `value`, `zero`.
  - Also used later by any multi-cycle unit.
- The FSM, the pending registers and HI/LO stay in `hilo_unit`.

## Test plan
- Reset, then idle: `hi_out` = `lo_out` = 0, `busy` = 0; MFHI gives `read_data` = 0 with `stall_req` = 0.
- MULT with `alu_hi`=00000001, `alu_lo`=65a0bc00 (2000000000×3):
  - `busy` is high for 4 cycles.
  - MFLO during BUSY gives `stall_req` = 1.
  - After commit, MFLO → 65a0bc00 and MFHI → 00000001.
- DIV 11/3 with `alu_hi`=2, `alu_lo`=3: commit after 12 edges, giving `hi_out` = 2, `lo_out` = 3.
  - A MULT issued in the commit cycle stalls exactly one cycle, then is accepted.
- DIV with `src_b`=0 and HI/LO preloaded via MTHI=AAAAAAAA, MTLO=5555FFFF:
  - After 12 cycles HI/LO are unchanged.
  - `div_zero` pulses for 1 cycle.
- Issue DIV, then assert `reset` on cycle 5:
  - HI/LO = 0 and `busy` = 0 immediately.
  - After release, MTLO `src_a`=0000002A gives `lo_out` = 2A on the next edge.
